// File: rtl/arm_if_id_ex_mem_slice.sv
// ---------------------------------------------------------------------------
// arm_if_id_ex_mem_slice
//   Three pieces of the ARM pipeline bundled in one block:
//     - fetch-stage PC incrementer (combinational)
//     - ID-stage control-unit decoder (combinational)
//     - EX/MEM control pipeline register (async active-low reset)
//
// Ports
//   Clk, Reset               : clock; asynchronous active-low reset
//   PC / NextPC              : current PC in, PC + PC_INCREMENT out
//   instruction              : ID-stage instruction word
//   ID_*                     : decoded control signals and 3-char ASCII mnemonic
//   EX_* / MEM_*             : EX-stage controls in, registered MEM copies out
// ---------------------------------------------------------------------------
module arm_if_id_ex_mem_slice #(
    parameter int unsigned PC_INCREMENT = 4
) (
    input  logic        Clk,
    input  logic        Reset,

    input  logic [31:0] PC,
    output logic [31:0] NextPC,

    input  logic [31:0] instruction,
    output logic        ID_S_bit,
    output logic        ID_load_instr,
    output logic        ID_RF_enable,
    output logic        ID_B_instr,
    output logic        ID_load_store_instr,
    output logic        ID_size,
    output logic        ID_BL_instr,
    output logic [1:0]  ID_shift_AM,
    output logic [3:0]  ID_alu_op,
    output logic [7:0]  ID_mnemonic0,
    output logic [7:0]  ID_mnemonic1,
    output logic [7:0]  ID_mnemonic2,

    input  logic        EX_load_store_instr,
    input  logic        EX_size,
    input  logic        EX_RF_enable,
    input  logic        EX_load_instr,
    output logic        MEM_load_store_instr,
    output logic        MEM_size,
    output logic        MEM_RF_enable,
    output logic        MEM_load_instr
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned AM_W   = 2;
    localparam int unsigned MN_W   = 24;

    // Shifter / addressing-mode selects
    localparam logic [AM_W-1:0] AM_IMM_ROT  = 2'b00;
    localparam logic [AM_W-1:0] AM_REG_SHFT = 2'b01;
    localparam logic [AM_W-1:0] AM_LS_IMM   = 2'b10;
    localparam logic [AM_W-1:0] AM_LS_REG   = 2'b11;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_ADC = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SBC = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_RSB = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_RSC = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_AND = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_ORR = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_EOR = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_MOV = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_MVN = 4'b1011;
    localparam logic [ALU_W-1:0] ALU_BIC = 4'b1100;

    // Instruction class field [27:25]
    localparam logic [2:0] CLS_DP_REG = 3'b000;
    localparam logic [2:0] CLS_DP_IMM = 3'b001;
    localparam logic [2:0] CLS_LS_IMM = 3'b010;
    localparam logic [2:0] CLS_LS_REG = 3'b011;
    localparam logic [2:0] CLS_BRANCH = 3'b101;

    // ------------------------------------------------------------------
    // Fetch-stage PC incrementer; carry out is dropped so the PC wraps.
    // ------------------------------------------------------------------
    always_comb begin
        NextPC = PC + XLEN'(PC_INCREMENT);
    end

    // ------------------------------------------------------------------
    // Data-processing opcode to ALU operation
    // ------------------------------------------------------------------
    function automatic logic [ALU_W-1:0] dp_alu_op(input logic [3:0] opcode);
        logic [ALU_W-1:0] op;
        case (opcode)
            4'b0000: op = ALU_AND;
            4'b0001: op = ALU_EOR;
            4'b0010: op = ALU_SUB;
            4'b0011: op = ALU_RSB;
            4'b0100: op = ALU_ADD;
            4'b0101: op = ALU_ADC;
            4'b0110: op = ALU_SBC;
            4'b0111: op = ALU_RSC;
            4'b1000: op = ALU_AND;   // TST
            4'b1001: op = ALU_EOR;   // TEQ
            4'b1010: op = ALU_SUB;   // CMP
            4'b1011: op = ALU_ADD;   // CMN
            4'b1100: op = ALU_ORR;
            4'b1101: op = ALU_MOV;
            4'b1110: op = ALU_BIC;
            default: op = ALU_MVN;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Data-processing opcode to 3-character ASCII mnemonic
    // ------------------------------------------------------------------
    function automatic logic [MN_W-1:0] dp_mnemonic(input logic [3:0] opcode);
        logic [MN_W-1:0] mn;
        case (opcode)
            4'b0000: mn = "AND";
            4'b0001: mn = "EOR";
            4'b0010: mn = "SUB";
            4'b0011: mn = "RSB";
            4'b0100: mn = "ADD";
            4'b0101: mn = "ADC";
            4'b0110: mn = "SBC";
            4'b0111: mn = "RSC";
            4'b1000: mn = "TST";
            4'b1001: mn = "TEQ";
            4'b1010: mn = "CMP";
            4'b1011: mn = "CMN";
            4'b1100: mn = "ORR";
            4'b1101: mn = "MOV";
            4'b1110: mn = "BIC";
            default: mn = "MVN";
        endcase
        return mn;
    endfunction

    // ------------------------------------------------------------------
    // ID-stage decoder. Condition field [31:28] plays no part.
    // ------------------------------------------------------------------
    logic [2:0]      cls;
    logic [3:0]      opcode;
    logic            is_nop;
    logic            mult_ext;   // 000 with bit7 & bit4: multiply / extra load-store space
    logic [MN_W-1:0] mnemonic;

    always_comb begin
        cls      = instruction[27:25];
        opcode   = instruction[24:21];
        is_nop   = (instruction == '0);
        mult_ext = instruction[7] & instruction[4];

        ID_S_bit            = 1'b0;
        ID_load_instr       = 1'b0;
        ID_RF_enable        = 1'b0;
        ID_B_instr          = 1'b0;
        ID_load_store_instr = 1'b0;
        ID_size             = 1'b0;
        ID_BL_instr         = 1'b0;
        ID_shift_AM         = AM_IMM_ROT;
        ID_alu_op           = ALU_ADD;
        mnemonic            = "UND";

        if (is_nop) begin
            mnemonic = "NOP";
        end else begin
            case (cls)
                CLS_DP_REG, CLS_DP_IMM: begin
                    if (cls == CLS_DP_IMM || !mult_ext) begin
                        ID_S_bit     = instruction[20];
                        ID_shift_AM  = (cls == CLS_DP_IMM) ? AM_IMM_ROT : AM_REG_SHFT;
                        // Compare/test opcodes (10xx) only update flags.
                        ID_RF_enable = (opcode[3:2] != 2'b10);
                        ID_alu_op    = dp_alu_op(opcode);
                        mnemonic     = dp_mnemonic(opcode);
                    end
                end
                CLS_LS_IMM, CLS_LS_REG: begin
                    ID_load_store_instr = 1'b1;
                    ID_load_instr       = instruction[20];
                    ID_size             = instruction[22];
                    ID_RF_enable        = instruction[20];
                    ID_shift_AM         = (cls == CLS_LS_IMM) ? AM_LS_IMM : AM_LS_REG;
                    // U bit selects add or subtract of the offset.
                    ID_alu_op           = instruction[23] ? ALU_ADD : ALU_SUB;
                    mnemonic            = instruction[20] ? "LDR" : "STR";
                end
                CLS_BRANCH: begin
                    ID_B_instr   = 1'b1;
                    ID_BL_instr  = instruction[24];
                    ID_RF_enable = instruction[24];   // link register write
                    mnemonic     = instruction[24] ? "BL " : "B  ";
                end
                default: begin
                    mnemonic = "UND";
                end
            endcase
        end

        ID_mnemonic0 = mnemonic[23:16];
        ID_mnemonic1 = mnemonic[15:8];
        ID_mnemonic2 = mnemonic[7:0];
    end

    // ------------------------------------------------------------------
    // EX/MEM control register: one-cycle copy, cleared asynchronously.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            MEM_load_store_instr <= 1'b0;
            MEM_size             <= 1'b0;
            MEM_RF_enable        <= 1'b0;
            MEM_load_instr       <= 1'b0;
        end else begin
            MEM_load_store_instr <= EX_load_store_instr;
            MEM_size             <= EX_size;
            MEM_RF_enable        <= EX_RF_enable;
            MEM_load_instr       <= EX_load_instr;
        end
    end

endmodule

// File: tb/tb_arm_if_id_ex_mem_slice.sv
module tb_arm_if_id_ex_mem_slice;

    logic        Clk;
    logic        Reset;
    logic [31:0] PC;
    logic [31:0] NextPC;
    logic [31:0] instruction;
    logic        ID_S_bit, ID_load_instr, ID_RF_enable, ID_B_instr;
    logic        ID_load_store_instr, ID_size, ID_BL_instr;
    logic [1:0]  ID_shift_AM;
    logic [3:0]  ID_alu_op;
    logic [7:0]  ID_mnemonic0, ID_mnemonic1, ID_mnemonic2;
    logic        EX_load_store_instr, EX_size, EX_RF_enable, EX_load_instr;
    logic        MEM_load_store_instr, MEM_size, MEM_RF_enable, MEM_load_instr;

    arm_if_id_ex_mem_slice #(.PC_INCREMENT(4)) dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .PC                   (PC),
        .NextPC               (NextPC),
        .instruction          (instruction),
        .ID_S_bit             (ID_S_bit),
        .ID_load_instr        (ID_load_instr),
        .ID_RF_enable         (ID_RF_enable),
        .ID_B_instr           (ID_B_instr),
        .ID_load_store_instr  (ID_load_store_instr),
        .ID_size              (ID_size),
        .ID_BL_instr          (ID_BL_instr),
        .ID_shift_AM          (ID_shift_AM),
        .ID_alu_op            (ID_alu_op),
        .ID_mnemonic0         (ID_mnemonic0),
        .ID_mnemonic1         (ID_mnemonic1),
        .ID_mnemonic2         (ID_mnemonic2),
        .EX_load_store_instr  (EX_load_store_instr),
        .EX_size              (EX_size),
        .EX_RF_enable         (EX_RF_enable),
        .EX_load_instr        (EX_load_instr),
        .MEM_load_store_instr (MEM_load_store_instr),
        .MEM_size             (MEM_size),
        .MEM_RF_enable        (MEM_RF_enable),
        .MEM_load_instr       (MEM_load_instr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // ctrl packing: {S, load, RF_en, B, load_store, size, BL, AM[1:0], alu[3:0]}
    typedef struct {
        logic [31:0] instr;
        logic [12:0] ctrl;
        logic [23:0] mn;
    } dec_vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] next_pc;
    } pc_vec_t;

    localparam int N_DEC = 17;
    localparam int N_PC  = 4;
    dec_vec_t dec_vecs[N_DEC];
    pc_vec_t  pc_vecs[N_PC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] id_ctrl();
        return 32'({ID_S_bit, ID_load_instr, ID_RF_enable, ID_B_instr,
                    ID_load_store_instr, ID_size, ID_BL_instr, ID_shift_AM, ID_alu_op});
    endfunction

    function automatic logic [31:0] mem_bits();
        return 32'({MEM_load_store_instr, MEM_size, MEM_RF_enable, MEM_load_instr});
    endfunction

    task automatic drive_ex(input logic [3:0] v);
        {EX_load_store_instr, EX_size, EX_RF_enable, EX_load_instr} = v;
    endtask

    initial begin
        pc_vecs[0] = '{32'h0000_0000, 32'h0000_0004};
        pc_vecs[1] = '{32'hFFFF_FFFC, 32'h0000_0000};
        pc_vecs[2] = '{32'h1234_5678, 32'h1234_567C};
        pc_vecs[3] = '{32'hFFFF_FFFE, 32'h0000_0002};

        dec_vecs[0]  = '{32'hE282_1005, 13'b0_0_1_0_0_0_0_00_0000, "ADD"};
        dec_vecs[1]  = '{32'hE151_0002, 13'b1_0_0_0_0_0_0_01_0010, "CMP"};
        dec_vecs[2]  = '{32'hE5D1_0004, 13'b0_1_1_0_1_1_0_10_0000, "LDR"};
        dec_vecs[3]  = '{32'hE701_0002, 13'b0_0_0_0_1_0_0_11_0010, "STR"};
        dec_vecs[4]  = '{32'hEB00_0004, 13'b0_0_1_1_0_0_1_00_0000, "BL "};
        dec_vecs[5]  = '{32'hEA00_0004, 13'b0_0_0_1_0_0_0_00_0000, "B  "};
        dec_vecs[6]  = '{32'h0000_0000, 13'b0_0_0_0_0_0_0_00_0000, "NOP"};
        dec_vecs[7]  = '{32'hE000_0090, 13'b0_0_0_0_0_0_0_00_0000, "UND"};
        dec_vecs[8]  = '{32'hE800_0000, 13'b0_0_0_0_0_0_0_00_0000, "UND"};
        dec_vecs[9]  = '{32'hEC00_0000, 13'b0_0_0_0_0_0_0_00_0000, "UND"};
        dec_vecs[10] = '{32'hE1B0_0001, 13'b1_0_1_0_0_0_0_01_1010, "MOV"};
        dec_vecs[11] = '{32'hE3C0_0001, 13'b0_0_1_0_0_0_0_00_1100, "BIC"};
        dec_vecs[12] = '{32'hE230_0001, 13'b1_0_1_0_0_0_0_00_1000, "EOR"};
        dec_vecs[13] = '{32'h0200_0090, 13'b0_0_1_0_0_0_0_00_0110, "AND"};
        dec_vecs[14] = '{32'hE1F0_0000, 13'b1_0_1_0_0_0_0_01_1011, "MVN"};
        dec_vecs[15] = '{32'hE130_0010, 13'b1_0_0_0_0_0_0_01_1000, "TEQ"};
        dec_vecs[16] = '{32'hF000_0000, 13'b0_0_1_0_0_0_0_01_0110, "AND"};

        Reset       = 1'b0;
        PC          = '0;
        instruction = '0;
        drive_ex(4'b0000);

        // Reset state of the EX/MEM register, with EX inputs active
        drive_ex(4'b1111);
        repeat (2) @(posedge Clk);
        #1 check("mem_in_reset", mem_bits(), 32'h0);

        // PC incrementer
        for (int i = 0; i < N_PC; i++) begin
            PC = pc_vecs[i].pc;
            #1 check($sformatf("next_pc[%0d]", i), NextPC, pc_vecs[i].next_pc);
        end

        // Decoder vectors
        for (int i = 0; i < N_DEC; i++) begin
            instruction = dec_vecs[i].instr;
            #1;
            check($sformatf("ctrl[%0d] %08h", i, dec_vecs[i].instr), id_ctrl(), 32'(dec_vecs[i].ctrl));
            check($sformatf("mnem[%0d] %08h", i, dec_vecs[i].instr),
                  32'({ID_mnemonic0, ID_mnemonic1, ID_mnemonic2}), 32'(dec_vecs[i].mn));
        end

        // EX/MEM: release reset mid-cycle, value appears only after the next edge
        @(negedge Clk);
        drive_ex(4'b1011);
        Reset = 1'b1;
        #1 check("mem_before_edge", mem_bits(), 32'h0);
        @(posedge Clk);
        #1 check("mem_after_edge", mem_bits(), 32'hB);

        // Next pattern exercises the other bit positions
        @(negedge Clk);
        drive_ex(4'b0101);
        #1 check("mem_hold_until_edge", mem_bits(), 32'hB);
        @(posedge Clk);
        #1 check("mem_second_capture", mem_bits(), 32'h5);

        // Asynchronous clear with all MEM outputs at 1
        @(negedge Clk);
        drive_ex(4'b1111);
        @(posedge Clk);
        #1 check("mem_all_ones", mem_bits(), 32'hF);
        #2 Reset = 1'b0;
        #1 check("mem_async_clear", mem_bits(), 32'h0);
        @(posedge Clk);
        #1 check("mem_held_in_reset", mem_bits(), 32'h0);

        // Release reset mid-cycle; first capture at the following edge
        #3 Reset = 1'b1;
        #1 check("mem_after_release", mem_bits(), 32'h0);
        @(posedge Clk);
        #1 check("mem_first_capture", mem_bits(), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm_if_id_ex_mem_slice.md
Name: arm_if_id_ex_mem_slice

Overview:
- Bundles three pipeline pieces of the ARM pipeline:
  - the fetch-stage PC incrementer;
  - the ID-stage combinational control-unit decoder;
  - the EX/MEM control pipeline register.
- PC and instruction come from the IF stage and IF/ID register.
- Decoded controls feed the ID/EX register via the NOP-select mux.
- EX-stage controls are registered into the MEM stage.

Parameters:
- PC_INCREMENT, 4, constant added to PC each fetch.

Ports:
- Clk  in  1  system clock; EX/MEM register captures on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- PC  in  32  current program counter.
- NextPC  out  32  PC + PC_INCREMENT.
- instruction  in  32  ID-stage instruction word.
- ID_S_bit  out  1  condition-flag update request.
- ID_load_instr  out  1  1 = load, 0 = store (valid with ID_load_store_instr).
- ID_RF_enable  out  1  register-file write enable.
- ID_B_instr  out  1  branch.
- ID_load_store_instr  out  1  memory access.
- ID_size  out  1  1 = byte, 0 = word.
- ID_BL_instr  out  1  branch-and-link.
- ID_shift_AM  out  2  addressing-mode / shifter select.
- ID_alu_op  out  4  ALU operation.
- ID_mnemonic0, ID_mnemonic1, ID_mnemonic2  out  8 each  ASCII mnemonic, characters 1..3.
- EX_load_store_instr, EX_size, EX_RF_enable, EX_load_instr  in  1 each  EX-stage controls.
- MEM_load_store_instr, MEM_size, MEM_RF_enable, MEM_load_instr  out  1 each  registered copies of the EX-stage controls.

Behaviour:
- Adder:
  - NextPC = (PC + PC_INCREMENT) mod 2^32, purely combinational.
  - 0xFFFFFFFC wraps to 0x00000000.
- Decoder:
  - Purely combinational.
  - Condition field [31:28] is ignored.
  - Every output not listed for a class is 0.
- Instruction == 0x00000000:
  - All controls 0; mnemonic "NOP".
- Data-processing, [27:25]=000 (excluding bit7=1 & bit4=1) or 001:
  - S = bit20.
  - AM = 00 for 001 (rotated 8-bit immediate); AM = 01 for 000 (register, shifted).
  - RF_enable = 1 except for TST/TEQ/CMP/CMN (opcode 10xx).
  - alu_op is mapped from opcode[24:21], with the mnemonic in parentheses:
    - 0000 (AND) -> 0110; 0001 (EOR) -> 1000; 0010 (SUB) -> 0010; 0011 (RSB) -> 0100.
    - 0100 (ADD) -> 0000; 0101 (ADC) -> 0001; 0110 (SBC) -> 0011; 0111 (RSC) -> 0101.
    - 1000 (TST) -> 0110; 1001 (TEQ) -> 1000; 1010 (CMP) -> 0010; 1011 (CMN) -> 0000.
    - 1100 (ORR) -> 0111; 1101 (MOV) -> 1010; 1110 (BIC) -> 1100; 1111 (MVN) -> 1011.
- Load/store, [27:25]=010 (AM 10, 12-bit immediate offset) or 011 (AM 11, register offset):
  - load_store_instr = 1.
  - load_instr = bit20 (L).
  - size = bit22 (B).
  - RF_enable = L.
  - alu_op = 0000 if bit23 (U) = 1, else 0010.
  - S = 0.
  - Mnemonic "LDR" or "STR".
- Branch, [27:25]=101:
  - B_instr = 1.
  - BL_instr = bit24.
  - RF_enable = bit24 (link write).
  - alu_op 0000, AM 00.
  - Mnemonic "B  " or "BL " (space padded).
- Any other encoding, including 000 with bit7 & bit4 set:
  - All controls 0; mnemonic "UND".
- EX/MEM register:
  - Reset low (asynchronous): all four MEM outputs = 0 immediately, and held at 0 while Reset is low.
  - Otherwise each rising Clk edge copies the EX inputs to the MEM outputs.
  - Latency 1 cycle; no enable and no stall.
  - Reset deasserting mid-cycle: the first capture occurs at the next rising edge.

Test Plan:
- PC=0x00000000 -> NextPC=0x00000004; PC=0xFFFFFFFC -> NextPC=0x00000000.
- instruction=0xE2821005 (ADD imm) -> alu_op 0000, AM 00, RF_en 1, S 0, "ADD"; instruction=0xE1510002 (CMP reg) -> alu_op 0010, AM 01, S 1, RF_en 0, "CMP".
- instruction=0xE5D10004 (LDRB imm, U=1) -> load_store 1, load 1, size 1, RF_en 1, alu_op 0000, AM 10, "LDR"; instruction=0xE7010002 (STR reg, U=0) -> load 0, size 0, RF_en 0, alu_op 0010, AM 11, "STR".
- instruction=0xEB000004 -> B 1, BL 1, RF_en 1, "BL "; instruction=0xEA000004 -> B 1, BL 0, RF_en 0, "B  "; instruction=0x00000000 -> all 0, "NOP".
- Drive EX inputs 1,0,1,1 (load_store, size, RF_enable, load) -> MEM outputs equal them after the next rising edge, unchanged before it.
- Pull Reset low mid-cycle while MEM outputs are 1 -> MEM outputs go to 0 with no clock edge and stay 0 until Reset returns high and an edge occurs.
